multichan_trigger: RTL
======================

Name: multichan_trigger

Overview:
- N-channel trigger front end that replaces the fixed two-channel trigger stage ahead of the waveform buffer.
- Per-channel threshold discrimination with gt/et/lt compare and time-over-threshold.
- Combines channels with M-of-N coincidence inside a programmable window; merges ext, sw and link triggers by fixed priority.
- Enforces a retrigger holdoff and delays the ADC stream so it is cycle-aligned with the trigger and source code.

Parameters:
P_N_CHAN, 2, number of ADC channels
P_ADC_BIT_WIDTH, 12, sample width
P_WINDOW_WIDTH, 4, coincidence window counter width (cycles)
P_HOLDOFF_WIDTH, 8, holdoff counter width (cycles)
P_CNT_WIDTH, 2, width of coinc_n; must be >= clog2(P_N_CHAN+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
adc_stream_in  in  P_N_CHAN*P_ADC_BIT_WIDTH  raw samples; channel k at bits [k*W +: W]
adc_stream_out  out  P_N_CHAN*P_ADC_BIT_WIDTH  samples delayed 2 cycles
thr  in  P_N_CHAN*P_ADC_BIT_WIDTH  per-channel threshold
gt, et, lt  in  1 each  compare mode bits, global
chan_en  in  P_N_CHAN  channel participates in coincidence
thresh_trig_en  in  1  enable threshold trigger
coinc_n  in  P_CNT_WIDTH  channels required; 0 disables the threshold trigger
coinc_window  in  P_WINDOW_WIDTH  window length in cycles
holdoff  in  P_HOLDOFF_WIDTH  dead cycles after a trigger
sw_run  in  1  software trigger; rising edge fires
ext_trig_en  in  1  enable external trigger
ext_run  in  1  asynchronous external trigger
link_en  in  1  enable link trigger
link_in  in  1  link trigger from neighbouring block; level-sampled
trig  out  1  one-cycle trigger pulse
trig_src  out  3  source code, valid while trig=1, else 0
thresh_tot  out  P_N_CHAN  per-channel over-threshold flag, aligned with adc_stream_out
holdoff_active  out  1  high while holdoff is counting
trig_count  out  32  accepted trigger count; wraps modulo 2^32

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; all pipeline, edge, window, holdoff and synchroniser registers cleared.
- Compare, per channel k: cond_k = (gt & s>thr) | (et & s==thr) | (lt & s<thr), unsigned.
- Stage 1 (t+1): register samples, cond_k, sw_run, link_in, and the synchronised ext_run.
- Stage 2 (t+2): register adc_stream_out, thresh_tot=cond_k, trig, trig_src.
- The sample at cycle t that produces a trigger appears on adc_stream_out in the same cycle as trig.
- hit_k = cond_k & ~prev_cond_k, evaluated in stage 1. prev_cond resets to 0, so a channel already over threshold at the first post-reset sample produces a hit.
- Window counter per channel:
  - On hit_k, load coinc_window.
  - Otherwise decrement to 0 and saturate there.
  - active_k = chan_en_k & (hit_k | win_k != 0).
- thresh_fire = thresh_trig_en & coinc_n != 0 & (any enabled hit_k) & popcount(active) >= coinc_n. A new hit is required, so a held window never refires.
- coinc_window=0 means hits must be simultaneous.
- ext_run: 2-flop synchroniser, then rising edge; gated by ext_trig_en. Adds 2 cycles of latency versus threshold triggers.
- sw_run: rising edge. link: link_en & link_in, level-sampled; every cycle it is high is a candidate.
- Priority when simultaneous: THRESH > EXT > SW > LINK. Only one trig is issued; lower-priority candidates in that cycle are dropped, not queued.
- Holdoff:
  - An accepted trig loads the holdoff counter with holdoff.
  - While the counter is nonzero, every candidate is suppressed; holdoff_active=1 and trig_count is not incremented.
  - holdoff=0 allows back-to-back triggers on consecutive cycles.
  - Window counters keep running during holdoff.
- trig_count increments on each trig=1.
- Config inputs may change at any time and take effect on the next compare; no state is reset by a config change.
- rst_n asserted mid-window or mid-holdoff: immediate clear; no trig is issued in the cycle rst_n releases.

Decomposition:
- Shared package trigger_pkg:
  - TRIG_SRC_NONE=0, TRIG_SRC_THRESH=1, TRIG_SRC_EXT=2, TRIG_SRC_SW=3, TRIG_SRC_LINK=4
  - 3-bit source width constant
- Existing 2-bit source users move to this package.
- Sub-module chan_discriminator holds the compare, prev_cond, hit and window counter, instanced P_N_CHAN times via generate.

Test Plan:
- N=2, coinc_n=1, gt=1, thr=100, ch0 steps 50->150 at cycle 10 -> trig=1, trig_src=1 at cycle 12; adc_stream_out ch0=150 at cycle 12; thresh_tot[0]=1 from cycle 12.
- coinc_n=2, window=3: ch0 hit at cycle 10, ch1 hit at 13 -> trig at 15. Repeat with ch1 at 14 -> no trig.
- holdoff=5; threshold, sw and link candidates at cycles 20, 22, 26 -> trig at 20 and 26 only; holdoff_active high for cycles 21..25; trig_count=2.
- Threshold hit and link_in high in the same cycle -> single trig, trig_src=1. Next cycle link_in high, holdoff=0 -> trig, trig_src=4.
- ext_trig_en=1, ext_run rises at cycle 30 -> trig_src=2 at cycle 34. Same with ext_trig_en=0 -> no trig.
- rst_n low for 1 cycle mid-holdoff at cycle 40 -> all outputs 0 immediately, trig_count=0. A channel held above threshold hits again at the first post-reset sample.

Source files
------------

// File: rtl/trigger_pkg.sv
// Trigger source codes and the source-priority helper shared by the trigger
// front end and downstream consumers of trig_src.
package trigger_pkg;

  localparam int TRIG_SRC_WIDTH = 3;

  typedef enum logic [TRIG_SRC_WIDTH-1:0] {
    TRIG_SRC_NONE   = 3'd0,
    TRIG_SRC_THRESH = 3'd1,
    TRIG_SRC_EXT    = 3'd2,
    TRIG_SRC_SW     = 3'd3,
    TRIG_SRC_LINK   = 3'd4
  } trig_src_e;

  // Fixed priority THRESH > EXT > SW > LINK; losers are dropped, not queued.
  function automatic trig_src_e trig_prio_sel(input logic thresh_fire,
                                              input logic ext_fire,
                                              input logic sw_fire,
                                              input logic link_fire);
    trig_src_e src;
    if (thresh_fire) begin
      src = TRIG_SRC_THRESH;
    end else if (ext_fire) begin
      src = TRIG_SRC_EXT;
    end else if (sw_fire) begin
      src = TRIG_SRC_SW;
    end else if (link_fire) begin
      src = TRIG_SRC_LINK;
    end else begin
      src = TRIG_SRC_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/chan_discriminator.sv
// One channel of threshold discrimination: compare, rising-edge hit detect and
// the coincidence window counter that keeps the channel active after a hit.
module chan_discriminator
  import trigger_pkg::*;
#(
  parameter int P_ADC_BIT_WIDTH = 12,
  parameter int P_WINDOW_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [P_ADC_BIT_WIDTH-1:0] sample,
  input  logic [P_ADC_BIT_WIDTH-1:0] thr,
  input  logic                       gt,
  input  logic                       et,
  input  logic                       lt,
  input  logic                       chan_en,
  input  logic [P_WINDOW_WIDTH-1:0]  coinc_window,
  output logic                       cond_o,
  output logic                       hit_o,
  output logic                       active_o
);

  logic                      cond_d, cond_q;
  logic                      prev_cond_d, prev_cond_q;
  logic                      hit;
  logic [P_WINDOW_WIDTH-1:0] win_d, win_q;

  always_comb begin
    cond_d      = (gt & (sample > thr)) | (et & (sample == thr)) | (lt & (sample < thr));
    prev_cond_d = cond_q;
    hit         = cond_q & ~prev_cond_q;
    if (hit) begin
      win_d = coinc_window;
    end else if (win_q != {P_WINDOW_WIDTH{1'b0}}) begin
      win_d = win_q - P_WINDOW_WIDTH'(1'b1);
    end else begin
      win_d = win_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q      <= 1'b0;
      prev_cond_q <= 1'b0;
      win_q       <= {P_WINDOW_WIDTH{1'b0}};
    end else begin
      cond_q      <= cond_d;
      prev_cond_q <= prev_cond_d;
      win_q       <= win_d;
    end
  end

  assign cond_o   = cond_q;
  assign hit_o    = hit;
  assign active_o = chan_en & (hit | (win_q != {P_WINDOW_WIDTH{1'b0}}));

endmodule

// File: rtl/multichan_trigger.sv
// N-channel trigger front end: M-of-N threshold coincidence merged with ext,
// sw and link triggers, retrigger holdoff, and a 2-cycle aligned sample delay.
module multichan_trigger
  import trigger_pkg::*;
#(
  parameter int P_N_CHAN        = 2,
  parameter int P_ADC_BIT_WIDTH = 12,
  parameter int P_WINDOW_WIDTH  = 4,
  parameter int P_HOLDOFF_WIDTH = 8,
  parameter int P_CNT_WIDTH     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [P_N_CHAN*P_ADC_BIT_WIDTH-1:0]   adc_stream_in,
  output logic [P_N_CHAN*P_ADC_BIT_WIDTH-1:0]   adc_stream_out,
  input  logic [P_N_CHAN*P_ADC_BIT_WIDTH-1:0]   thr,
  input  logic                                  gt,
  input  logic                                  et,
  input  logic                                  lt,
  input  logic [P_N_CHAN-1:0]                   chan_en,
  input  logic                                  thresh_trig_en,
  input  logic [P_CNT_WIDTH-1:0]                coinc_n,
  input  logic [P_WINDOW_WIDTH-1:0]             coinc_window,
  input  logic [P_HOLDOFF_WIDTH-1:0]            holdoff,
  input  logic                                  sw_run,
  input  logic                                  ext_trig_en,
  input  logic                                  ext_run,
  input  logic                                  link_en,
  input  logic                                  link_in,
  output logic                                  trig,
  output logic [TRIG_SRC_WIDTH-1:0]             trig_src,
  output logic [P_N_CHAN-1:0]                   thresh_tot,
  output logic                                  holdoff_active,
  output logic [31:0]                           trig_count
);

  localparam int LP_BUS_W = P_N_CHAN * P_ADC_BIT_WIDTH;

  logic [P_N_CHAN-1:0] cond, hit, active;

  for (genvar k = 0; k < P_N_CHAN; k++) begin : g_chan
    chan_discriminator #(
      .P_ADC_BIT_WIDTH(P_ADC_BIT_WIDTH),
      .P_WINDOW_WIDTH (P_WINDOW_WIDTH)
    ) u_disc (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample      (adc_stream_in[k*P_ADC_BIT_WIDTH +: P_ADC_BIT_WIDTH]),
      .thr         (thr[k*P_ADC_BIT_WIDTH +: P_ADC_BIT_WIDTH]),
      .gt          (gt),
      .et          (et),
      .lt          (lt),
      .chan_en     (chan_en[k]),
      .coinc_window(coinc_window),
      .cond_o      (cond[k]),
      .hit_o       (hit[k]),
      .active_o    (active[k])
    );
  end

  logic [LP_BUS_W-1:0]        samp_d, samp_q, adc_out_d, adc_out_q;
  logic                       sw_d, sw_q, sw_prev_d, sw_prev_q;
  logic                       link_d, link_q;
  logic                       ext_meta_d, ext_meta_q, ext_sync_d, ext_sync_q;
  logic                       ext_d, ext_q, ext_prev_d, ext_prev_q;
  logic [P_N_CHAN-1:0]        tot_d, tot_q;
  logic                       trig_d, trig_q;
  trig_src_e                  src_d, src_q, cand_src;
  logic [P_HOLDOFF_WIDTH-1:0] hold_d, hold_q;
  logic                       hold_act_d, hold_act_q;
  logic [31:0]                count_d, count_q;
  logic [P_CNT_WIDTH-1:0]     act_cnt;
  logic                       thresh_fire, ext_fire, sw_fire, link_fire;

  always_comb begin
    act_cnt = {P_CNT_WIDTH{1'b0}};
    for (int k = 0; k < P_N_CHAN; k++) begin
      act_cnt = act_cnt + P_CNT_WIDTH'(active[k]);
    end
    // A fresh enabled hit is required, so a window that is merely held open never refires.
    thresh_fire = thresh_trig_en & (coinc_n != {P_CNT_WIDTH{1'b0}}) &
                  (|(hit & chan_en)) & (act_cnt >= coinc_n);
    ext_fire    = ext_trig_en & ext_q & ~ext_prev_q;
    sw_fire     = sw_q & ~sw_prev_q;
    link_fire   = link_en & link_q;
    cand_src    = trig_prio_sel(thresh_fire, ext_fire, sw_fire, link_fire);
  end

  always_comb begin
    samp_d     = adc_stream_in;
    sw_d       = sw_run;
    sw_prev_d  = sw_q;
    link_d     = link_in;
    ext_meta_d = ext_run;
    ext_sync_d = ext_meta_q;
    ext_d      = ext_sync_q;
    ext_prev_d = ext_q;
    adc_out_d  = samp_q;
    tot_d      = cond;
    hold_act_d = (hold_q != {P_HOLDOFF_WIDTH{1'b0}});
    if ((hold_q == {P_HOLDOFF_WIDTH{1'b0}}) && (cand_src != TRIG_SRC_NONE)) begin
      trig_d = 1'b1;
      src_d  = cand_src;
    end else begin
      trig_d = 1'b0;
      src_d  = TRIG_SRC_NONE;
    end
    // Loaded in the trigger cycle itself so holdoff=0 permits back-to-back triggers.
    if (trig_d) begin
      hold_d = holdoff;
    end else if (hold_q != {P_HOLDOFF_WIDTH{1'b0}}) begin
      hold_d = hold_q - P_HOLDOFF_WIDTH'(1'b1);
    end else begin
      hold_d = hold_q;
    end
    if (trig_d) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= {LP_BUS_W{1'b0}};
      sw_q       <= 1'b0;
      sw_prev_q  <= 1'b0;
      link_q     <= 1'b0;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      ext_q      <= 1'b0;
      ext_prev_q <= 1'b0;
      adc_out_q  <= {LP_BUS_W{1'b0}};
      tot_q      <= {P_N_CHAN{1'b0}};
      trig_q     <= 1'b0;
      src_q      <= TRIG_SRC_NONE;
      hold_q     <= {P_HOLDOFF_WIDTH{1'b0}};
      hold_act_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      samp_q     <= samp_d;
      sw_q       <= sw_d;
      sw_prev_q  <= sw_prev_d;
      link_q     <= link_d;
      ext_meta_q <= ext_meta_d;
      ext_sync_q <= ext_sync_d;
      ext_q      <= ext_d;
      ext_prev_q <= ext_prev_d;
      adc_out_q  <= adc_out_d;
      tot_q      <= tot_d;
      trig_q     <= trig_d;
      src_q      <= src_d;
      hold_q     <= hold_d;
      hold_act_q <= hold_act_d;
      count_q    <= count_d;
    end
  end

  assign adc_stream_out = adc_out_q;
  assign thresh_tot     = tot_q;
  assign trig           = trig_q;
  assign trig_src       = src_q;
  assign holdoff_active = hold_act_q;
  assign trig_count     = count_q;

endmodule
